ibex_sram_arbiter: RTL and testbench
====================================

Name: ibex_sram_arbiter

Overview:
- Two-master to one-slave arbiter between the Ibex instruction and data ports and a single-port SRAM (ram_1p, 1-cycle read latency).
- Replaces the fixed instruction-priority glue in the top level with four additions:
  - same-cycle grant;
  - round-robin fairness;
  - response routing to the issuing port;
  - an error response for out-of-range addresses.

Parameters:
- MemStart, 32'h00000000, base byte address of the SRAM window.
- MemSize, 65536, window size in bytes; power of two, >= 4. MemMask = MemSize-1 is derived, not a parameter.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset; asynchronous assert, active-low
- instr_req_i  in  1  instruction request
- instr_gnt_o  out  1  instruction grant (combinational)
- instr_addr_i  in  32  instruction byte address
- instr_rvalid_o  out  1  instruction response valid
- instr_rdata_o  out  32  instruction read data
- instr_err_o  out  1  instruction bus error, qualified by rvalid
- data_req_i  in  1  data request
- data_gnt_o  out  1  data grant (combinational)
- data_we_i  in  1  data write enable
- data_be_i  in  4  data byte enables
- data_addr_i  in  32  data byte address
- data_wdata_i  in  32  data write data
- data_rvalid_o  out  1  data response valid (reads and writes)
- data_rdata_o  out  32  data read data
- data_err_o  out  1  data bus error, qualified by rvalid
- mem_req_o  out  1  SRAM request
- mem_we_o  out  1  SRAM write enable
- mem_be_o  out  4  SRAM byte enables
- mem_addr_o  out  32  SRAM address, byte offset = addr & MemMask
- mem_wdata_o  out  32  SRAM write data
- mem_rvalid_i  in  1  SRAM read valid, one cycle after mem_req_o
- mem_rdata_i  in  32  SRAM read data

Behaviour:
- Request decode:
  - in_range(a) = ((a & ~MemMask) == MemStart).
  - Ibex protocol: req held until gnt; response (rvalid) exactly one cycle after gnt.
- Arbitration, per cycle and combinational:
  - Only one req asserted: that port wins.
  - Both asserted: the winner is the port not favoured by rr_q. rr_q = 0 means instr won the last conflict, so data wins now.
  - rr_q updates only on a conflict cycle, to the winner.
  - Exactly one gnt per cycle at most. The loser sees gnt=0 and holds its req.
- Granted and in range:
  - mem_req_o=1.
  - Instr: mem_we_o=0, mem_be_o=4'hF.
  - Data: we, be and wdata passed through.
- Granted and out of range:
  - gnt still asserted; mem_req_o=0 (no SRAM access).
  - Error response issued next cycle.
- Idle (no grant): mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0.
- Response pipeline registers:
  - resp_valid_q, resp_port_q (0=instr, 1=data), resp_err_q.
  - Loaded every cycle from the current grant.
- Next-cycle responses:
  - In-range grant → rvalid on the issuing port, rdata = mem_rdata_i, err=0. Applies to data writes too.
  - Out-of-range grant → rvalid=1, err=1, rdata=32'h0.
  - The non-issuing port has rvalid=0, err=0, rdata=0.
- Back-to-back: a new grant may be issued in the same cycle the previous response returns. Throughput is one transaction per cycle.
- Reset:
  - rr_q=0, resp_valid_q=0, resp_err_q=0, resp_port_q=0.
  - Hence instr/data rvalid_o=0, err_o=0, rdata_o=0.
  - gnt_o and mem_* are combinational from req and still follow inputs during reset. The core holds req low in reset.
- Reset asserted mid-transaction: the pending response is dropped, with no rvalid after reset release.
- Protocol checks (simulation assertions):
  - mem_rvalid_i must equal the delayed (in-range grant) flag.
  - instr_gnt_o and data_gnt_o are never both high.

Test Plan:
- Instr read only: instr_req=1, addr=32'h80 → instr_gnt=1 same cycle, mem_addr=32'h80, mem_be=4'hF; next cycle instr_rvalid=1, instr_rdata=mem_rdata (e.g. 32'h00000013), data_rvalid=0.
- Data write: data_req=1, we=1, be=4'b0011, addr=32'h1000, wdata=32'hDEADBEEF → mem_req=1, mem_we=1, mem_be=4'b0011; next cycle data_rvalid=1, data_err=0.
- Conflict fairness: both req held for 4 cycles from reset → grants in order data, instr, data, instr; rr_q toggles each cycle; each rvalid lands on the correct port one cycle after its grant.
- Out of range: data_req=1, addr=32'h0001_0000 (MemSize=64 kB) → data_gnt=1, mem_req=0; next cycle data_rvalid=1, data_err=1, data_rdata=0.
- Back-to-back instr stream at addr 0x80, 0x84, 0x88 → three consecutive gnts, three consecutive rvalids with matching rdata order.
- Reset mid-operation: grant at cycle N, assert rst_ni low before cycle N+1 edge → no rvalid on either port, rr_q=0 after release.

Source files
------------

// File: rtl/ibex_sram_arbiter.sv
// Round-robin arbiter between the Ibex instruction and data ports and one
// single-port SRAM, with response routing and an error response for misses.
module ibex_sram_arbiter #(
  parameter logic [31:0] MemStart = 32'h0000_0000,
  parameter int unsigned MemSize  = 65536
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [31:0] MemMask = 32'(MemSize - 1);

  logic instr_in_range;
  logic data_in_range;
  logic conflict;
  logic grant_instr;
  logic grant_data;
  logic granted;
  logic grant_in_range;

  // rr_q is high when data won the most recent conflict
  logic rr_q;
  logic resp_valid_q;
  logic resp_port_q;
  logic resp_err_q;
  logic resp_ok;

  assign instr_in_range = (instr_addr_i & ~MemMask) == MemStart;
  assign data_in_range  = (data_addr_i & ~MemMask) == MemStart;

  assign conflict       = instr_req_i & data_req_i;
  assign grant_data     = data_req_i & (~instr_req_i | ~rr_q);
  assign grant_instr    = instr_req_i & ~grant_data;
  assign granted        = grant_instr | grant_data;
  assign grant_in_range = grant_data ? data_in_range : (grant_instr & instr_in_range);

  assign instr_gnt_o = grant_instr;
  assign data_gnt_o  = grant_data;

  // Out-of-range grants leave the SRAM untouched
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (grant_instr && instr_in_range) begin
      mem_req_o  = 1'b1;
      mem_be_o   = 4'hF;
      mem_addr_o = instr_addr_i & MemMask;
    end else if (grant_data && data_in_range) begin
      mem_req_o   = 1'b1;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i & MemMask;
      mem_wdata_o = data_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_port_q  <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      if (conflict) begin
        rr_q <= grant_data;
      end
      resp_valid_q <= granted;
      resp_port_q  <= grant_data;
      resp_err_q   <= granted & ~grant_in_range;
    end
  end

  assign resp_ok = resp_valid_q & ~resp_err_q;

  assign instr_rvalid_o = resp_valid_q & ~resp_port_q;
  assign instr_err_o    = resp_valid_q & ~resp_port_q & resp_err_q;
  assign instr_rdata_o  = (resp_ok & ~resp_port_q) ? mem_rdata_i : 32'h0;

  assign data_rvalid_o  = resp_valid_q & resp_port_q;
  assign data_err_o     = resp_valid_q & resp_port_q & resp_err_q;
  assign data_rdata_o   = (resp_ok & resp_port_q) ? mem_rdata_i : 32'h0;

  // The SRAM must answer exactly the accesses issued a cycle earlier
  a_mem_rvalid_match: assert property (
    @(posedge clk_i) disable iff (!rst_ni) mem_rvalid_i == resp_ok
  );

  a_single_grant: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(instr_gnt_o && data_gnt_o)
  );

endmodule

// File: tb/tb_ibex_sram_arbiter.sv
// Bench for ibex_sram_arbiter: directed vector table, hand sequences for reset
// and streaming, then random masters checked against a transaction-level model.
module tb_ibex_sram_arbiter;

  localparam logic [31:0] MEM_START = 32'h0000_0000;
  localparam logic [31:0] MEM_MASK  = 32'h0000_FFFF;

  logic        clk_i;
  logic        rst_ni;
  logic        instr_req_i;
  logic        instr_gnt_o;
  logic [31:0] instr_addr_i;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  ibex_sram_arbiter #(
    .MemStart(MEM_START),
    .MemSize (65536)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .instr_req_i   (instr_req_i),
    .instr_gnt_o   (instr_gnt_o),
    .instr_addr_i  (instr_addr_i),
    .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o (instr_rdata_o),
    .instr_err_o   (instr_err_o),
    .data_req_i    (data_req_i),
    .data_gnt_o    (data_gnt_o),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .data_err_o    (data_err_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_be_o      (mem_be_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        eig;
    logic        edg;
    logic        emreq;
    logic        emwe;
    logic [3:0]  embe;
    logic [31:0] emaddr;
  } vec_t;

  typedef struct {
    bit          port;
    bit          err;
    logic [31:0] data;
  } resp_t;

  int    n_cmp;
  int    n_fail;
  bit    last_data_won;
  bit    model_gnt_i;
  bit    model_gnt_d;
  resp_t resp_q[$];
  vec_t  tbl[11];

  logic [31:0] sram [0:16383];
  bit          sram_written [0:16383];
  logic [31:0] ref_mem [0:16383];
  bit          ref_written [0:16383];
  logic [13:0] sram_idx;

  function automatic logic [31:0] default_word(input logic [13:0] w);
    if (w == 14'd32) return 32'h0000_0013;
    return ({18'h0, w} * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic bit in_range(input logic [31:0] a);
    return (a & ~MEM_MASK) == MEM_START;
  endfunction

  function automatic logic [13:0] word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a & MEM_MASK;
    return off[15:2];
  endfunction

  // Behavioural single-port SRAM with one-cycle read latency
  assign sram_idx = mem_addr_o[15:2];
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_rvalid_i <= 1'b0;
    end else begin
      mem_rvalid_i <= mem_req_o;
      if (mem_req_o) begin
        mem_rdata_i <= sram_written[sram_idx] ? sram[sram_idx] : default_word(sram_idx);
        if (mem_we_o) begin
          sram[sram_idx] <= merge(sram_written[sram_idx] ? sram[sram_idx] :
                                  default_word(sram_idx), mem_wdata_o, mem_be_o);
          sram_written[sram_idx] <= 1'b1;
        end
      end
    end
  end

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [13:0] w;
    w = word_of(a);
    return ref_written[w] ? ref_mem[w] : default_word(w);
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [13:0] w;
    w = word_of(a);
    ref_mem[w]     = merge(ref_read(a), d, be);
    ref_written[w] = 1'b1;
  endtask

  task automatic cmp1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic cmp32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                                 input logic dwe, input logic [3:0] dbe, input logic [31:0] daddr,
                                 input logic [31:0] dwdata, input logic eig, input logic edg,
                                 input logic emreq, input logic emwe, input logic [3:0] embe,
                                 input logic [31:0] emaddr);
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe; v.dbe = dbe;
    v.daddr = daddr; v.dwdata = dwdata; v.eig = eig; v.edg = edg; v.emreq = emreq;
    v.emwe = emwe; v.embe = embe; v.emaddr = emaddr;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    instr_req_i  = v.ireq;
    instr_addr_i = v.iaddr;
    data_req_i   = v.dreq;
    data_we_i    = v.dwe;
    data_be_i    = v.dbe;
    data_addr_i  = v.daddr;
    data_wdata_i = v.dwdata;
  endtask

  task automatic idleInputs();
    applyStimulus(mkVec(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0));
  endtask

  // Transaction-level reference: decide the winner from the fairness rule,
  // check outputs, then queue the response the winner should see next cycle.
  task automatic checkOutput(input string tag);
    resp_t       cur;
    resp_t       nxt;
    bit          has_cur;
    bit          win_i;
    bit          win_d;
    bit          ok;
    logic [31:0] a;
    cur = '{port: 1'b0, err: 1'b0, data: 32'h0};
    has_cur = resp_q.size() > 0;
    if (has_cur) cur = resp_q.pop_front();
    if (instr_req_i && data_req_i) begin
      win_d = !last_data_won;
      win_i = last_data_won;
      last_data_won = win_d;
    end else begin
      win_i = instr_req_i;
      win_d = data_req_i;
    end
    a  = win_d ? data_addr_i : instr_addr_i;
    ok = (win_i || win_d) && in_range(a);
    cmp1({tag, ".instr_gnt"}, instr_gnt_o, win_i);
    cmp1({tag, ".data_gnt"}, data_gnt_o, win_d);
    cmp1({tag, ".mem_req"}, mem_req_o, ok);
    cmp1({tag, ".mem_we"}, mem_we_o, ok && win_d && data_we_i);
    cmp32({tag, ".mem_be"}, 32'(mem_be_o), ok ? (win_d ? 32'(data_be_i) : 32'hF) : 32'h0);
    cmp32({tag, ".mem_addr"}, mem_addr_o, ok ? (a & MEM_MASK) : 32'h0);
    cmp32({tag, ".mem_wdata"}, mem_wdata_o, (ok && win_d) ? data_wdata_i : 32'h0);
    cmp1({tag, ".instr_rvalid"}, instr_rvalid_o, has_cur && !cur.port);
    cmp1({tag, ".instr_err"}, instr_err_o, has_cur && !cur.port && cur.err);
    cmp32({tag, ".instr_rdata"}, instr_rdata_o, (has_cur && !cur.port) ? cur.data : 32'h0);
    cmp1({tag, ".data_rvalid"}, data_rvalid_o, has_cur && cur.port);
    cmp1({tag, ".data_err"}, data_err_o, has_cur && cur.port && cur.err);
    cmp32({tag, ".data_rdata"}, data_rdata_o, (has_cur && cur.port) ? cur.data : 32'h0);
    if (win_i || win_d) begin
      nxt.port = win_d;
      nxt.err  = !ok;
      nxt.data = ok ? ref_read(a) : 32'h0;
      resp_q.push_back(nxt);
    end
    if (ok && win_d && data_we_i) ref_write(a, data_be_i, data_wdata_i);
    model_gnt_i = win_i;
    model_gnt_d = win_d;
  endtask

  task automatic cycle(input string tag);
    @(negedge clk_i);
    checkOutput(tag);
    @(posedge clk_i);
    #1;
  endtask

  task automatic doReset();
    rst_ni = 1'b0;
    idleInputs();
    resp_q.delete();
    last_data_won = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    cmp1("reset.instr_rvalid", instr_rvalid_o, 1'b0);
    cmp1("reset.data_rvalid", data_rvalid_o, 1'b0);
    cmp1("reset.instr_err", instr_err_o, 1'b0);
    cmp1("reset.data_err", data_err_o, 1'b0);
    cmp32("reset.instr_rdata", instr_rdata_o, 32'h0);
    cmp32("reset.data_rdata", data_rdata_o, 32'h0);
    cmp1("reset.mem_req", mem_req_o, 1'b0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] randAddr();
    if ($urandom_range(0, 7) == 0)
      return {16'($urandom_range(1, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFC};
    return 32'h0000_1000 | (32'($urandom_range(0, 63)) << 2);
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_ni = 1'b1;
    idleInputs();

    // Directed table, applied straight after reset so rr starts favouring data
    tbl[0]  = mkVec(1, 32'h80, 1, 0, 4'hF, 32'h1000, 32'h0, 0, 1, 1, 0, 4'hF, 32'h1000);
    tbl[1]  = mkVec(1, 32'h80, 1, 0, 4'hF, 32'h1000, 32'h0, 1, 0, 1, 0, 4'hF, 32'h80);
    tbl[2]  = mkVec(1, 32'h80, 1, 0, 4'hF, 32'h1000, 32'h0, 0, 1, 1, 0, 4'hF, 32'h1000);
    tbl[3]  = mkVec(1, 32'h80, 1, 0, 4'hF, 32'h1000, 32'h0, 1, 0, 1, 0, 4'hF, 32'h80);
    tbl[4]  = mkVec(1, 32'h80, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 1, 0, 4'hF, 32'h80);
    tbl[5]  = mkVec(0, 32'h0, 1, 1, 4'h3, 32'h1000, 32'hDEADBEEF, 0, 1, 1, 1, 4'h3, 32'h1000);
    tbl[6]  = mkVec(0, 32'h0, 1, 0, 4'hF, 32'h1000, 32'h0, 0, 1, 1, 0, 4'hF, 32'h1000);
    tbl[7]  = mkVec(0, 32'h0, 1, 0, 4'hF, 32'h0001_0000, 32'h0, 0, 1, 0, 0, 4'h0, 32'h0);
    tbl[8]  = mkVec(1, 32'hFFFF_0080, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 0, 4'h0, 32'h0);
    tbl[9]  = mkVec(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0, 4'h0, 32'h0);
    tbl[10] = mkVec(0, 32'h0, 1, 1, 4'hF, 32'h0002_0000, 32'h1234_5678, 0, 1, 0, 0, 4'h0, 32'h0);

    doReset();
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i]);
      @(negedge clk_i);
      cmp1($sformatf("vec%0d.tbl_instr_gnt", i), instr_gnt_o, tbl[i].eig);
      cmp1($sformatf("vec%0d.tbl_data_gnt", i), data_gnt_o, tbl[i].edg);
      cmp1($sformatf("vec%0d.tbl_mem_req", i), mem_req_o, tbl[i].emreq);
      cmp1($sformatf("vec%0d.tbl_mem_we", i), mem_we_o, tbl[i].emwe);
      cmp32($sformatf("vec%0d.tbl_mem_be", i), 32'(mem_be_o), 32'(tbl[i].embe));
      cmp32($sformatf("vec%0d.tbl_mem_addr", i), mem_addr_o, tbl[i].emaddr);
      checkOutput($sformatf("vec%0d", i));
      @(posedge clk_i);
      #1;
    end
    idleInputs();
    cycle("vec_drain");

    // Back-to-back instruction stream
    for (int k = 0; k < 3; k++) begin
      applyStimulus(mkVec(1, 32'h80 + 32'(4 * k), 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0));
      @(negedge clk_i);
      cmp1($sformatf("b2b%0d.gnt", k), instr_gnt_o, 1'b1);
      checkOutput($sformatf("b2b%0d", k));
      @(posedge clk_i);
      #1;
    end
    idleInputs();
    cycle("b2b_drain");

    // Reset in the cycle after a grant: the response must vanish
    applyStimulus(mkVec(1, 32'h80, 1, 0, 4'hF, 32'h1004, 0, 0, 0, 0, 0, 4'h0, 0));
    cycle("rst_pre");
    applyStimulus(mkVec(1, 32'h84, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0));
    @(negedge clk_i);
    checkOutput("rst_gnt");
    rst_ni = 1'b0;
    #1;
    cmp1("rst_async.data_rvalid", data_rvalid_o, 1'b0);
    cmp32("rst_async.data_rdata", data_rdata_o, 32'h0);
    idleInputs();
    resp_q.delete();
    last_data_won = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    cycle("rst_after0");
    applyStimulus(mkVec(1, 32'h88, 1, 0, 4'hF, 32'h1008, 0, 0, 0, 0, 0, 4'h0, 0));
    @(negedge clk_i);
    cmp1("rst_rr.data_first", data_gnt_o, 1'b1);
    checkOutput("rst_rr");
    @(posedge clk_i);
    #1;
    idleInputs();
    cycle("rst_drain");

    // Random masters obeying hold-until-grant
    for (int c = 0; c < 400; c++) begin
      cycle("rand");
      if (!instr_req_i || model_gnt_i) begin
        instr_req_i  = ($urandom_range(0, 9) < 6);
        instr_addr_i = randAddr();
      end
      if (!data_req_i || model_gnt_d) begin
        data_req_i   = ($urandom_range(0, 9) < 6);
        data_addr_i  = randAddr();
        data_we_i    = 1'($urandom_range(0, 1));
        data_be_i    = 4'($urandom_range(1, 15));
        data_wdata_i = $urandom;
      end
    end
    idleInputs();
    cycle("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
